skewed_vector_feeder: RTL and testbench
=======================================

SKEWED_VECTOR_FEEDER -- requirements
Module: skewed_vector_feeder

Interface
REQ-001 Parameter DIM, default 4: matrix dimension and lane count; legal range 2..64.
REQ-002 Parameter WIDTH, default 8: element width in bits.
REQ-003 Parameter SKEW, default 1: 1 = lane i delayed by i beats (systolic wavefront); 0 = no delay.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 mode  input  1  0 = row mode, 1 = column mode; sampled only on load handshake.
REQ-007 in_valid  input  1  matrix offered on in_data.
REQ-008 in_ready  output  1  feeder can accept a matrix.
REQ-009 in_data  input  DIM*DIM*WIDTH  matrix M[r][c], packed [DIM-1:0][DIM-1:0][WIDTH-1:0], outer index r.
REQ-010 out_valid  output  1  out_data holds a valid beat.
REQ-011 out_ready  input  1  consumer accepts the current beat.
REQ-012 out_data  output  DIM*WIDTH  lanes [DIM-1:0][WIDTH-1:0].
REQ-013 out_last  output  1  current beat is the final beat of the matrix.
REQ-014 busy  output  1  high in STREAM state.
REQ-015 done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-016 Two-state FSM: IDLE, STREAM; N = DIM + SKEW*(DIM-1) beats per matrix; beat counter k is $clog2(N+1) bits.
REQ-017 IDLE: in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
REQ-018 IDLE and in_valid=1: capture in_data into the internal buffer and mode into a mode register, set k=0, go to STREAM next cycle.
REQ-019 STREAM: in_ready=0, out_valid=1, busy=1; in_valid ignored and buffer unchanged.
REQ-020 Lane i source index j = k - SKEW*i; if j<0 or j>=DIM, lane i = 0.
REQ-021 Otherwise lane i = M[j][i] in row mode and M[i][j] in column mode.
REQ-022 out_data and out_last are functions of registered state only (buffer, mode register, k); no combinational path from in_* or out_ready.
REQ-023 Beat accepted when out_valid && out_ready: k increments by 1.
REQ-024 out_ready=0: k, out_data, and out_last hold stable for any number of cycles.
REQ-025 out_last=1 exactly when STREAM and k==N-1.
REQ-026 Accepted beat with out_last=1: go to IDLE; done=1 for the next cycle only; k returns to 0.
REQ-027 Back-to-back matrices: earliest next load is the cycle done is high, giving exactly one bubble cycle between matrices.
REQ-028 The feeder emits exactly N beats per loaded matrix; k never exceeds N-1 and never wraps.
REQ-029 mode changes during STREAM have no effect until the next load.

Reset
REQ-030 reset_n low drives IDLE, k=0, done=0, mode register=0, buffer=0 immediately, independent of clk.
REQ-031 Reset asserted mid-STREAM abandons the matrix with no done pulse; after release in_ready=1 on the first cycle.
REQ-032 Outputs during reset equal the IDLE values of REQ-017 with done=0.

Verification
Common setup: DIM=4, WIDTH=8; M[r][c] = 0x10*(r+1) + (c+1), so M[0][0]=0x11 and M[3][3]=0x44. Lanes are listed lane0..lane3.
REQ-033 SKEW=0, row mode, out_ready=1 -> 4 beats; beat1 = 0x21,0x22,0x23,0x24; out_last on beat3; done one cycle after beat3.
REQ-034 SKEW=1, row mode -> 7 beats:
  - beat0 = 0x11,0,0,0
  - beat3 = 0x41,0x32,0x23,0x14
  - beat6 = 0,0,0,0x44, with out_last=1
REQ-035 SKEW=1, column mode -> beat1 = 0x12,0x21,0,0; beat6 = 0,0,0,0x44.
REQ-036 SKEW=1, out_ready toggled 1,0,0,1 repeatedly -> identical beat sequence to REQ-034, stable while stalled, exactly 7 accepted beats.
REQ-037 reset_n pulsed low during beat2 of a SKEW=1 matrix -> out_valid=0 and in_ready=1 after release; no done; next matrix streams correctly from beat0.
REQ-038 in_valid held high continuously -> matrices load on cycles 0, 8, 16 (one bubble each); in_data changed during STREAM does not affect out_data.

Source files
------------

// File: rtl/skewed_vector_feeder.sv
// Skewed vector feeder: loads a DIM x DIM matrix, then streams it out one beat
// per accepted handshake as DIM lanes (rows or columns), optionally skewed so
// lane i trails lane i-1 by one beat to form a systolic wavefront.
module skewed_vector_feeder #(
  parameter int unsigned DIM   = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SKEW  = 1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  mode,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]    in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DIM-1:0][WIDTH-1:0]             out_data,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned N  = DIM + SKEW * (DIM - 1);
  localparam int unsigned KW = $clog2(N + 1);
  localparam int unsigned DW = $clog2(DIM);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                              state_q, state_d;
  logic [KW-1:0]                       k_q, k_d;
  logic                                mode_q;
  logic                                done_q, done_d;
  logic                                load;
  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]  buf_q;

  // State, beat counter, done pulse and captured matrix/mode registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      done_q  <= done_d;
      if (load) begin
        mode_q <= mode;
        buf_q  <= in_data;
      end
    end
  end

  // Next-state logic and handshake decode from the current state
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    done_d    = 1'b0;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          k_d     = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = (k_q == KW'(N - 1));
        if (out_ready) begin
          if (k_q == KW'(N - 1)) begin
            k_d     = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane selection: lane i reads element k - SKEW*i of its row/column, else zero
  always_comb begin
    int j;
    out_data = '0;
    j        = 0;
    if (state_q == STREAM) begin
      for (int i = 0; i < int'(DIM); i++) begin
        j = int'(k_q) - int'(SKEW) * i;
        if (j >= 0 && j < int'(DIM)) begin
          out_data[DW'(i)] = mode_q ? buf_q[DW'(i)][DW'(j)] : buf_q[DW'(j)][DW'(i)];
        end
      end
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_skewed_vector_feeder.sv
// Directed bench for skewed_vector_feeder: one unskewed and one skewed instance.
module tb_skewed_vector_feeder;

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic                        mode;
  logic                        valid0, valid1;
  logic                        out_ready;
  logic [3:0][3:0][7:0]        in_data;
  logic                        rdy0, rdy1, ov0, ov1, last0, last1, busy0, busy1, done0, done1;
  logic [3:0][7:0]             od0, od1;
  logic [3:0][3:0][7:0]        mat, alt;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  skewed_vector_feeder #(.DIM(4), .WIDTH(8), .SKEW(0)) u0 (
    .clk(clk), .reset_n(reset_n), .mode(mode), .in_valid(valid0), .in_ready(rdy0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_last(last0), .busy(busy0), .done(done0));

  skewed_vector_feeder #(.DIM(4), .WIDTH(8), .SKEW(1)) u1 (
    .clk(clk), .reset_n(reset_n), .mode(mode), .in_valid(valid1), .in_ready(rdy1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_last(last1), .busy(busy1), .done(done1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beat for the common matrix M[r][c] = 0x10*(r+1) + (c+1)
  function automatic logic [31:0] model(input int skew, input bit col, input int k);
    logic [31:0] r;
    int j;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      j = k - skew * i;
      if (j >= 0 && j < 4)
        r[i*8 +: 8] = col ? 8'(16 * (i + 1) + (j + 1)) : 8'(16 * (j + 1) + (i + 1));
    end
    return r;
  endfunction

  initial begin
    int acc, dones, cyc, nload;
    int loads[3];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mat[r][c] = 8'(16 * (r + 1) + (c + 1));
        alt[r][c] = 8'hA5;
      end
    reset_n = 1'b0; mode = 1'b0; valid0 = 1'b0; valid1 = 1'b0; out_ready = 1'b1;
    in_data = mat;
    #12;
    // Outputs while reset is held
    chk("rst_in_ready", 64'(rdy1), 64'h1);
    chk("rst_out_valid", 64'(ov1), 64'h0);
    chk("rst_out_data", 64'(od1), 64'h0);
    chk("rst_out_last", 64'(last1), 64'h0);
    chk("rst_busy", 64'(busy1), 64'h0);
    chk("rst_done", 64'(done1), 64'h0);
    reset_n = 1'b1;
    tick();

    // SKEW=0 row mode
    valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    chk("s0_busy", 64'(busy0), 64'h1);
    chk("s0_in_ready", 64'(rdy0), 64'h0);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("s0_beat%0d", b), 64'(od0), 64'(model(0, 1'b0, b)));
      chk($sformatf("s0_last%0d", b), 64'(last0), 64'(b == 3));
      if (b == 1) chk("s0_beat1_hand", 64'(od0), 64'h24232221);
      tick();
    end
    chk("s0_done", 64'(done0), 64'h1);
    chk("s0_idle_valid", 64'(ov0), 64'h0);
    chk("s0_idle_data", 64'(od0), 64'h0);
    tick();
    chk("s0_done_pulse", 64'(done0), 64'h0);

    // SKEW=1 row mode
    mode = 1'b0; valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    mode = 1'b1;  // must not affect the matrix in flight
    for (int b = 0; b < 7; b++) begin
      chk($sformatf("s1r_beat%0d", b), 64'(od1), 64'(model(1, 1'b0, b)));
      chk($sformatf("s1r_last%0d", b), 64'(last1), 64'(b == 6));
      if (b == 0) chk("s1r_beat0_hand", 64'(od1), 64'h00000011);
      if (b == 3) chk("s1r_beat3_hand", 64'(od1), 64'h14233241);
      if (b == 6) chk("s1r_beat6_hand", 64'(od1), 64'h44000000);
      tick();
    end
    chk("s1r_done", 64'(done1), 64'h1);
    tick();

    // SKEW=1 column mode
    mode = 1'b1; valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    for (int b = 0; b < 7; b++) begin
      chk($sformatf("s1c_beat%0d", b), 64'(od1), 64'(model(1, 1'b1, b)));
      if (b == 1) chk("s1c_beat1_hand", 64'(od1), 64'h00002112);
      if (b == 6) chk("s1c_beat6_hand", 64'(od1), 64'h44000000);
      tick();
    end
    chk("s1c_done", 64'(done1), 64'h1);
    tick();

    // SKEW=1 row mode with out_ready pattern 1,0,0,1
    mode = 1'b0; valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    acc = 0; dones = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      if (done1) dones++;
      if (ov1) begin
        chk($sformatf("stall_c%0d", c), 64'(od1), 64'(model(1, 1'b0, acc)));
        chk($sformatf("stall_last_c%0d", c), 64'(last1), 64'(acc == 6));
        if (out_ready) acc++;
      end
      tick();
    end
    out_ready = 1'b1;
    chk("stall_accepted", 64'(acc), 64'd7);
    chk("stall_dones", 64'(dones), 64'd1);

    // Reset during beat2
    valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    tick();
    tick();
    chk("rst_mid_beat2", 64'(od1), 64'h00132231);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(ov1), 64'h0);
    chk("rst_mid_ready", 64'(rdy1), 64'h1);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_after_ready", 64'(rdy1), 64'h1);
    chk("rst_after_valid", 64'(ov1), 64'h0);
    chk("rst_after_done", 64'(done1), 64'h0);
    valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    chk("rst_next_beat0", 64'(od1), 64'h00000011);
    for (int b = 0; b < 7; b++) tick();
    chk("rst_next_done", 64'(done1), 64'h1);
    tick();

    // in_valid held high: loads every 8 cycles, in_data changes ignored mid-stream
    valid1 = 1'b1;
    in_data = mat;
    nload = 0;
    for (int c = 0; c < 18; c++) begin
      cyc = c;
      if (c == 3) in_data = alt;
      if (rdy1) begin
        if (nload < 3) loads[nload] = cyc;
        nload++;
      end
      if (c >= 1 && c <= 7)
        chk($sformatf("b2b_beat%0d", c - 1), 64'(od1), 64'(model(1, 1'b0, c - 1)));
      tick();
    end
    valid1 = 1'b0;
    chk("b2b_nload", 64'(nload), 64'd3);
    chk("b2b_load0", 64'(loads[0]), 64'd0);
    chk("b2b_load1", 64'(loads[1]), 64'd8);
    chk("b2b_load2", 64'(loads[2]), 64'd16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
